// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter.
package mem_arb_pkg;
   localparam int N_REQ_DEF   = 2;
   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 128;
   localparam int TIMEOUT_DEF = 255;
   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} arb_state_t;
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [ADDR_W_DEF-1:0] addr;
      logic                  rw;
      logic                  valid;
   } mem_req_t;
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  ready;
   } mem_rsp_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin chooser, first set bit after last_i.
module rr_picker import mem_arb_pkg::*; #(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] last_i,
   output logic [$clog2(N_REQ)-1:0] grant_o,
   output logic                     any_o
);
   localparam int GW = $clog2(N_REQ);
   // Scan farthest offset first so the nearest set bit after last_i wins.
   always_comb begin
      grant_o = '0;
      any_o = |req_i;
      for (int k = N_REQ; k >= 1; k--)
         if (req_i[(int'(last_i) + k) % N_REQ]) grant_o = GW'((int'(last_i) + k) % N_REQ);
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one line-granular memory port.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_rw,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      mem_req_valid,
   output logic                      mem_req_rw,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic [DATA_W-1:0]         mem_req_data,
   input  logic                      mem_rsp_ready,
   input  logic [DATA_W-1:0]         mem_rsp_data,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy,
   output logic                      timeout_err
);
   localparam int GW = $clog2(N_REQ);
   arb_state_t        state_q;
   logic [GW-1:0]     last_q, grant_q, pick;
   logic              any, rw_q, expire;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q, rsp_q;
   logic [N_REQ-1:0]  ready_q;
   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req_i   (req_valid),
      .last_i  (last_q),
      .grant_o (pick),
      .any_o   (any)
   );
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q;
   logic          tout_q;
   assign expire = cnt_q == CW'(TIMEOUT_CYC - 1);
   assign timeout_err = tout_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         tout_q <= 1'b0;
      end else begin
         cnt_q <= (state_q == ISSUE && !mem_rsp_ready) ? cnt_q + 1'b1 : '0;
         if (state_q == ISSUE && !mem_rsp_ready && expire) tout_q <= 1'b1;
      end
   end
`else
   assign expire = TIMEOUT_CYC < 0;
   assign timeout_err = 1'b0;
`endif
   assign mem_req_valid = state_q == ISSUE;
   assign busy = state_q != IDLE;
   assign mem_req_rw = rw_q;
   assign mem_req_addr = addr_q;
   assign mem_req_data = data_q;
   assign grant_id = grant_q;
   assign req_ready = ready_q;
   assign rsp_data = rsp_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q <= GW'(N_REQ - 1);
         grant_q <= '0;
         rw_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         ready_q <= '0;
         rsp_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (any) begin
               grant_q <= pick;
               last_q <= pick;
               rw_q <= req_rw[pick];
               addr_q <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
               data_q <= req_data[int'(pick)*DATA_W +: DATA_W];
               state_q <= ISSUE;
            end
            ISSUE: if (mem_rsp_ready || expire) begin
               ready_q <= N_REQ'(1) << grant_q;
               rsp_q <= mem_rsp_ready ? mem_rsp_data : '0;
               state_q <= RELEASE;
            end
            RELEASE: begin
               ready_q <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus multi-cycle sequences.
module tb_mem_port_arbiter;
   logic          clk = 0, rst = 0;
   logic [1:0]    req_valid = '0, req_rw = '0, req_ready;
   logic [63:0]   req_addr = '0;
   logic [255:0]  req_data = '0;
   logic [127:0]  rsp_data, mem_req_data, mem_rsp_data = '0;
   logic          mem_req_valid, mem_req_rw, mem_rsp_ready = 0, busy, timeout_err;
   logic [31:0]   mem_req_addr;
   logic          grant_id;
   int            errs = 0, checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(128), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .rsp_data(rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      logic [1:0]   v, rw;
      logic [31:0]  a0, a1;
      logic [127:0] d0, d1, md;
      int           lat;
      logic         gid, erw;
      logic [31:0]  ea;
      logic [127:0] ed;
   } vec_t;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " ctl"}, {req_ready, mem_req_valid, mem_req_rw, grant_id, busy, timeout_err}, '0);
      chk({nm, " addr"}, mem_req_addr, '0);
      chk({nm, " wdata"}, mem_req_data, '0);
      chk({nm, " rsp"}, rsp_data, '0);
   endtask

   task automatic apply(input logic [1:0] v, input logic [1:0] rw, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [127:0] d0, input logic [127:0] d1);
      req_valid = v; req_rw = rw; req_addr = {a1, a0}; req_data = {d1, d0};
   endtask

   task automatic wait_issue(input string nm);
      int n = 0;
      while (!mem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 128'(n), 128'd1);
   endtask

   task automatic do_txn(input string nm, input int lat, input logic [127:0] md, input logic gid, input logic erw,
                         input logic [31:0] ea, input logic [127:0] ed, input bit hold, input bit drop);
      wait_issue(nm);
      chk({nm, " grant"}, grant_id, gid);
      chk({nm, " rw"}, mem_req_rw, erw);
      chk({nm, " addr"}, mem_req_addr, ea);
      chk({nm, " wdata"}, mem_req_data, ed);
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         if (drop && i == 1) req_valid = '0;
      end
      chk({nm, " held"}, {mem_req_valid, busy, mem_req_addr}, {2'b11, ea});
      mem_rsp_ready = 1; mem_rsp_data = md;
      @(negedge clk);
      mem_rsp_ready = 0; mem_rsp_data = '0;
      chk({nm, " ready"}, req_ready, gid ? 2'b10 : 2'b01);
      chk({nm, " rsp"}, rsp_data, md);
      chk({nm, " release"}, {mem_req_valid, busy}, 2'b01);
      if (!hold) req_valid = '0;
      @(negedge clk);
      chk({nm, " idle"}, {req_ready, busy}, 3'b000);
   endtask

   vec_t tbl[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{2'b01, 2'b00, 32'h8000_4000, 32'h0, 128'h0, 128'h0, {16{8'hA5}}, 3, 1'b0, 1'b0, 32'h8000_4000, 128'h0};
      tbl[1] = '{2'b10, 2'b10, 32'h0, 32'h0000_2000, 128'h0, {4{32'h5555_AAAA}}, 128'h1, 2, 1'b1, 1'b1, 32'h0000_2000, {4{32'h5555_AAAA}}};
      tbl[2] = '{2'b11, 2'b10, 32'h8000_4010, 32'h0000_1000, 128'h0, 128'h0123456789ABCDEF_FEDCBA9876543210,
                 {4{32'hCAFE_F00D}}, 2, 1'b0, 1'b0, 32'h8000_4010, 128'h0};
      tbl[3] = '{2'b11, 2'b10, 32'h8000_4010, 32'h0000_1000, 128'h0, 128'h0123456789ABCDEF_FEDCBA9876543210,
                 128'h77, 2, 1'b1, 1'b1, 32'h0000_1000, 128'h0123456789ABCDEF_FEDCBA9876543210};
      tbl[4] = '{2'b10, 2'b00, 32'h0, 32'h0000_3000, 128'h0, 128'h0, {8{16'hBEEF}}, 1, 1'b1, 1'b0, 32'h0000_3000, 128'h0};
      tbl[5] = '{2'b01, 2'b01, 32'h8000_5000, 32'h0, {16{8'h3C}}, 128'h0, 128'h1234, 4, 1'b0, 1'b1, 32'h8000_5000, {16{8'h3C}}};

      @(negedge clk);
      chk_zero("reset");
      rst = 1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         apply(tbl[i].v, tbl[i].rw, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
         do_txn($sformatf("vec%0d", i), tbl[i].lat, tbl[i].md, tbl[i].gid, tbl[i].erw, tbl[i].ea, tbl[i].ed, 0, 0);
      end

      apply(2'b10, 2'b00, 32'h0, 32'h0000_4000, 128'h0, 128'h0);
      do_txn("drop", 3, 128'h99, 1'b1, 1'b0, 32'h0000_4000, 128'h0, 0, 1);
      mem_rsp_ready = 1; mem_rsp_data = 128'hBAD;
      @(negedge clk);
      mem_rsp_ready = 0; mem_rsp_data = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("drop no regrant", {req_ready, busy, mem_req_valid}, 4'b0000);
      end

      apply(2'b11, 2'b10, 32'h0000_0100, 32'h0000_0200, 128'h0, 128'hF0F0);
      for (int i = 0; i < 6; i++)
         do_txn($sformatf("rr%0d", i), 2, 128'(i + 16), 1'(i % 2), 1'(i % 2),
                (i % 2) ? 32'h0000_0200 : 32'h0000_0100, (i % 2) ? 128'hF0F0 : 128'h0, i < 5, 0);

      apply(2'b01, 2'b00, 32'h8000_6000, 32'h0000_6000, 128'h0, 128'h0);
      wait_issue("rst mid");
      chk("rst mid grant", grant_id, 1'b0);
      #2 rst = 0;
      #1 chk_zero("rst mid");
      apply(2'b11, 2'b00, 32'h8000_6000, 32'h0000_6000, 128'h0, 128'h0);
      @(negedge clk);
      rst = 1;
      do_txn("after rst", 2, 128'h42, 1'b0, 1'b0, 32'h8000_6000, 128'h0, 0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
      begin
         int n = 0;
         apply(2'b01, 2'b00, 32'h8000_7000, 32'h0, 128'h0, 128'h0);
         wait_issue("tmo");
         while (req_ready == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("tmo cycles", 128'(n), 128'd16);
         chk("tmo flag", {timeout_err, req_ready}, 3'b101);
         chk("tmo rsp", rsp_data, '0);
         req_valid = '0;
         @(negedge clk);
         apply(2'b10, 2'b00, 32'h0, 32'h0000_7000, 128'h0, 128'h0);
         do_txn("post tmo", 2, 128'h55, 1'b1, 1'b0, 32'h0000_7000, 128'h0, 0, 0);
         chk("tmo sticky", timeout_err, 1'b1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
